axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: word-index width; the array holds 2^ADDR_W words of 64 bits (32 KiB at the default).
REQ-002 SHALL have parameter INIT_FILE, default "": hex image loaded at time zero; an empty string means no load.
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 AR: arvalid in 1; araddr in 64; arid in 4; arlen in 8; arsize in 3; arburst in 2; arready out 1.
REQ-007 R: rvalid out 1; rdata out 64; rresp out 2; rid out 4; rlast out 1; rready in 1.
REQ-008 AW: awvalid in 1; awaddr in 64; awid in 4; awlen in 8; awsize in 3; awburst in 2; awready out 1.
REQ-009 W: wvalid in 1; wdata in 64; wstrb in 8; wlast in 1; wready out 1.
REQ-010 B: bvalid out 1; bresp out 2; bid out 4; bready in 1.

Function
REQ-011 SHALL act as the downstream AXI4 slave for the cache-side AXI master, with the read and write engines fully independent.
REQ-012 Read FSM SHALL have states R_IDLE and R_DATA; arready = (state==R_IDLE).
REQ-013 On AR handshake: latch araddr, arid, arlen, arsize, arburst; clear beat counter; go to R_DATA. rvalid SHALL rise on the next cycle (1-cycle latency).
REQ-014 rdata SHALL be registered: loaded from mem[addr[ADDR_W+2:3]] on entry to R_DATA and on each non-last R handshake.
REQ-015 rdata, rresp, rid and rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-016 Address step per beat: INCR (01) adds 1<<size; FIXED (00) keeps the address.
REQ-017 rlast SHALL be 1 exactly when beat counter == latched len.
REQ-018 R handshake with rlast=1 SHALL return the FSM to R_IDLE; a new AR SHALL be accepted no earlier than the following cycle.
REQ-019 rresp per beat: DECERR (11) if addr[63:ADDR_W+3] != 0; else SLVERR (10) if burst is 10 or 11 or size > 3; else OKAY (00).
REQ-020 rdata SHALL be 0 on any error beat.
REQ-021 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready = (state==W_IDLE); wready = (state==W_DATA).
REQ-022 On AW handshake: latch awaddr, awid, awlen, awsize, awburst; clear beat counter and the error flag; go to W_DATA.
REQ-023 On each W handshake: if the beat is legal (per REQ-019 rules) and counter <= len, write bytes i where wstrb[i]=1; advance address and counter.
REQ-024 W handshake with wlast=1 SHALL move the FSM to W_RESP.
REQ-025 If wlast=1 arrives with counter != len, or any beat arrives with counter > len, bresp SHALL be SLVERR; beats with counter > len SHALL NOT be written.
REQ-026 bresp SHALL be DECERR/SLVERR if any beat of the burst was an error beat (DECERR takes priority), else OKAY.
REQ-027 In W_RESP: bvalid=1, bid = latched awid; B handshake returns the FSM to W_IDLE.
REQ-028 Same-cycle write commit and rdata load to the same word SHALL give rdata the pre-write value.
REQ-029 Narrow reads SHALL return the full aligned 64-bit word; the master selects the bytes.

Reset
REQ-030 While rst=0: both FSMs idle, counters 0; arready=1, awready=1; rvalid, rlast, wready, bvalid = 0; rdata, rresp, rid, bresp, bid = 0.
REQ-031 Reset mid-burst SHALL abort the transaction with no further beats or response; array contents SHALL be retained (not cleared).

Verification
REQ-032 Single read: AR addr 0x10, len 0, size 3, id 5 with mem[2]=0xDEADBEEF -> next cycle rvalid=1, rdata=0xDEADBEEF, rlast=1, rid=5, rresp=00.
REQ-033 INCR write burst: AW addr 0x100, len 1, size 3; two beats wstrb FF, second with wlast -> mem[0x20], mem[0x21] written; bvalid with bresp 00; read-back of the same words matches.
REQ-034 Backpressure: 2-beat read with rready held low 3 cycles per beat -> rdata/rlast stable throughout; exactly 2 beats; rlast only on beat 2.
REQ-035 Strobe: write 0x1122334455667788 with wstrb 0x0F over a word of 0 -> read returns 0x0000000055667788.
REQ-036 Errors: AR addr 1<<40 -> rresp 11, rdata 0; AW len 3 with wlast on beat 1 -> bresp 10, only beats 0-1 written.
REQ-037 Concurrency/reset: read and write bursts issued in the same cycle both complete independently; rst pulled low mid-read -> rvalid=0 immediately, arready=1, memory unchanged.

Source files
------------

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 slave fronting a 64-bit wide SRAM array
// Read and write engines run independently; the array itself is never reset.
module axi_sram_slave #(
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [63:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        arready,
  output logic        rvalid,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic [3:0]  rid,
  output logic        rlast,
  input  logic        rready,
  input  logic        awvalid,
  input  logic [63:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        awready,
  input  logic        wvalid,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        bready
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [63:0] mem [0:(1<<ADDR_W)-1];

  // DECERR outranks SLVERR; bad_kind flags WRAP/reserved bursts or sizes above 8 bytes
  function automatic logic [1:0] beat_resp(input logic [63-ADDR_W-3:0] hi, input logic bad_kind);
    if (hi != '0) return 2'b11;
    if (bad_kind) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] addr_step(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b01) ? (64'd1 << size) : 64'd0;
  endfunction

  logic [0:0]  r_state;
  logic [63:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_cnt;
  logic        ar_hs, r_hs;
  logic [63:0] r_next, ld_addr, ld_word;
  logic        ld_bad;
  logic [1:0]  ld_resp;
  logic        unused_bits;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;

  // Next beat's word is fetched from araddr on acceptance, else from the stepped address
  assign r_next  = r_addr + addr_step(r_burst, r_size);
  assign ld_addr = (r_state == R_IDLE) ? araddr : r_next;
  assign ld_bad  = (r_state == R_IDLE) ? (arburst[1] | (arsize > 3'd3))
                                       : (r_burst[1] | (r_size > 3'd3));
  assign ld_resp = beat_resp(ld_addr[63:ADDR_W+3], ld_bad);
  assign ld_word = mem[ld_addr[ADDR_W+2:3]];
  assign unused_bits = ^ld_addr[2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rid     <= '0;
      rlast   <= 1'b0;
    end else if (ar_hs) begin
      r_state <= R_DATA;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= '0;
      rid     <= arid;
      rlast   <= (arlen == 8'd0);
      rresp   <= ld_resp;
      rdata   <= (ld_resp == 2'b00) ? ld_word : 64'd0;
    end else if (r_hs) begin
      if (rlast) begin
        r_state <= R_IDLE;
        rlast   <= 1'b0;
      end else begin
        r_addr <= r_next;
        r_cnt  <= r_cnt + 8'd1;
        rlast  <= ((r_cnt + 8'd1) == r_len);
        rresp  <= ld_resp;
        rdata  <= (ld_resp == 2'b00) ? ld_word : 64'd0;
      end
    end
  end

  logic [1:0]  w_state;
  logic [63:0] w_addr;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [8:0]  w_cnt;
  logic        w_dec, w_slv;
  logic        aw_hs, w_hs, b_hs;
  logic [1:0]  w_resp;
  logic        w_over, w_commit, dec_n, slv_n;

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;

  // Counter is one bit wider than len so beats past the burst end stay detectable
  assign w_resp   = beat_resp(w_addr[63:ADDR_W+3], w_burst[1] | (w_size > 3'd3));
  assign w_over   = (w_cnt > {1'b0, w_len});
  assign w_commit = w_hs & (w_resp == 2'b00) & ~w_over;
  assign dec_n    = w_dec | (w_resp == 2'b11);
  assign slv_n    = w_slv | (w_resp == 2'b10) | w_over | (wlast & (w_cnt != {1'b0, w_len}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_dec   <= 1'b0;
      w_slv   <= 1'b0;
      bresp   <= '0;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_state <= W_DATA;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          bid     <= awid;
          w_cnt   <= '0;
          w_dec   <= 1'b0;
          w_slv   <= 1'b0;
        end
        W_DATA: if (w_hs) begin
          w_addr <= w_addr + addr_step(w_burst, w_size);
          if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
          w_dec <= dec_n;
          w_slv <= slv_n;
          if (wlast) begin
            w_state <= W_RESP;
            bresp   <= dec_n ? 2'b11 : (slv_n ? 2'b10 : 2'b00);
          end
        end
        W_RESP: if (b_hs) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[w_addr[ADDR_W+2:3]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed and randomized checks of axi_sram_slave
// Expected data comes from a word-array model updated with closed-form beat addresses.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arvalid = 0; logic [63:0] araddr = 0; logic [3:0] arid = 0; logic [7:0] arlen = 0;
  logic [2:0] arsize = 0; logic [1:0] arburst = 0; logic arready;
  logic rvalid; logic [63:0] rdata; logic [1:0] rresp; logic [3:0] rid; logic rlast; logic rready = 0;
  logic awvalid = 0; logic [63:0] awaddr = 0; logic [3:0] awid = 0; logic [7:0] awlen = 0;
  logic [2:0] awsize = 0; logic [1:0] awburst = 0; logic awready;
  logic wvalid = 0; logic [63:0] wdata = 0; logic [7:0] wstrb = 0; logic wlast = 0; logic wready;
  logic bvalid; logic [1:0] bresp; logic [3:0] bid; logic bready = 0;

  int total = 0;
  int bad = 0;
  logic [63:0] model [0:(1<<AW)-1];
  logic [63:0] wdat [0:259];
  logic [7:0]  wstb [0:259];

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(AW), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bid(bid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [1:0] burst,
                                            input logic [2:0] size, input int b);
    return (burst == 2'b01) ? a + 64'(b) * (64'd1 << size) : a;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [63:0] a, input logic [1:0] burst,
                                          input logic [2:0] size);
    if ((a >> (AW + 3)) != 64'd0) return 2'b11;
    if (burst >= 2'd2 || size > 3'd3) return 2'b10;
    return 2'b00;
  endfunction

  task automatic do_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    logic [63:0] a;
    logic [1:0] r, eb;
    bit dec, slv;
    int n;
    dec = 0; slv = 0;
    for (int b = 0; b < nbeats; b++) begin
      a = beat_addr(addr, burst, size, b);
      r = exp_resp(a, burst, size);
      if (r == 2'b11) dec = 1;
      if (r == 2'b10) slv = 1;
      if (b > int'(len)) slv = 1;
      if (r == 2'b00 && b <= int'(len))
        for (int i = 0; i < 8; i++)
          if (wstb[b][i]) model[a[AW+2:3]][8*i +: 8] = wdat[b][8*i +: 8];
    end
    if (nbeats - 1 != int'(len)) slv = 1;
    eb = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);

    awvalid = 1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    awvalid = 0;
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1; wdata = wdat[b]; wstrb = wstb[b]; wlast = (b == nbeats - 1);
      n = 0;
      while (!wready && n < 50) begin @(posedge clk); #1; n++; end
      check("w_wait", 64'(n < 50), 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("b_wait", 64'(n < 50), 64'd1);
    check("bresp", 64'(bresp), 64'(eb));
    check("bid", 64'(bid), 64'(id));
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("b_done", 64'(bvalid), 64'd0);
    check("awready_back", 64'(awready), 64'd1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall);
    logic [63:0] a, ed;
    logic [1:0] r;
    int n;
    arvalid = 1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    arvalid = 0;
    check("r_latency", 64'(rvalid), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      a = beat_addr(addr, burst, size, b);
      r = exp_resp(a, burst, size);
      ed = (r == 2'b00) ? model[a[AW+2:3]] : 64'd0;
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      check("r_wait", 64'(n < 50), 64'd1);
      for (int s = 0; s <= stall; s++) begin
        check("rdata", rdata, ed);
        check("rresp", 64'(rresp), 64'(r));
        check("rid", 64'(rid), 64'(id));
        check("rlast", 64'(rlast), 64'(b == int'(len)));
        if (s < stall) begin @(posedge clk); #1; end
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
    end
    check("r_done", 64'(rvalid), 64'd0);
    check("arready_back", 64'(arready), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addr;
    logic [7:0] len;
    int nb;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    rst = 1;
    @(posedge clk); #1;

    // Fill the whole array so every later read has a defined expectation
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 256; b++) begin
        wdat[b] = {$urandom, $urandom};
        wstb[b] = 8'hFF;
      end
      do_write(64'(k) * 64'd2048, 4'(k), 8'd255, 3'd3, 2'b01, 256);
    end

    wdat[0] = 64'hDEADBEEF; wstb[0] = 8'hFF;
    do_write(64'h10, 4'd1, 8'd0, 3'd3, 2'b01, 1);
    do_read(64'h10, 4'd5, 8'd0, 3'd3, 2'b01, 0);

    wdat[0] = 64'hA5A5_0000_1111_2222; wdat[1] = 64'h0123_4567_89AB_CDEF;
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    do_write(64'h100, 4'd2, 8'd1, 3'd3, 2'b01, 2);
    do_read(64'h100, 4'd3, 8'd1, 3'd3, 2'b01, 0);
    do_read(64'h100, 4'd4, 8'd1, 3'd3, 2'b01, 3);

    wdat[0] = 64'd0; wstb[0] = 8'hFF;
    do_write(64'h200, 4'd6, 8'd0, 3'd3, 2'b01, 1);
    wdat[0] = 64'h1122334455667788; wstb[0] = 8'h0F;
    do_write(64'h200, 4'd6, 8'd0, 3'd3, 2'b01, 1);
    do_read(64'h200, 4'd7, 8'd0, 3'd3, 2'b01, 0);
    check("strobe_word", model[64'h200 >> 3], 64'h0000000055667788);

    do_read(64'd1 << 40, 4'd8, 8'd1, 3'd3, 2'b01, 0);
    for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    do_write(64'h400, 4'd9, 8'd3, 3'd3, 2'b01, 2);
    do_read(64'h400, 4'd9, 8'd3, 3'd3, 2'b01, 1);
    do_read(64'h10, 4'd1, 8'd1, 3'd3, 2'b10, 0);
    do_read(64'h10, 4'd1, 8'd0, 3'd4, 2'b01, 0);

    for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    fork
      do_write(64'h2000, 4'd10, 8'd3, 3'd3, 2'b01, 4);
      do_read(64'h100, 4'd11, 8'd1, 3'd3, 2'b01, 1);
    join
    do_read(64'h2000, 4'd12, 8'd3, 3'd3, 2'b01, 0);

    // Reset in the middle of a held read burst
    arvalid = 1; araddr = 64'h2000; arid = 4'd13; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01;
    @(posedge clk); #1;
    arvalid = 0;
    check("mid_rvalid", 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid), 64'd0);
    check("rst_mid_arready", 64'(arready), 64'd1);
    check("rst_mid_rlast", 64'(rlast), 64'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("post_rst_rvalid", 64'(rvalid), 64'd0);
    do_read(64'h2000, 4'd14, 8'd3, 3'd3, 2'b01, 0);

    for (int it = 0; it < 24; it++) begin
      addr = 64'($urandom_range(0, (1 << AW) - 1)) * 64'd8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr = addr | (64'd1 << 40);
      len = 8'($urandom_range(0, 7));
      nb = int'(len) + 1;
      case ($urandom_range(0, 5))
        0: nb = int'(len) + 2;
        1: if (len != 0) nb = int'(len);
        default: ;
      endcase
      for (int b = 0; b < nb; b++) begin
        wdat[b] = {$urandom, $urandom};
        wstb[b] = 8'($urandom);
      end
      begin
        logic [2:0] sz;
        logic [1:0] bu;
        sz = 3'($urandom_range(0, 4));
        bu = 2'($urandom_range(0, 2));
        do_write(addr, 4'($urandom), len, sz, bu, nb);
        do_read(addr, 4'($urandom), len, sz, bu, $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
